// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             nb;
    logic             last;
    logic [WIDTH:0]   sr_cat;
    logic [WIDTH-1:0] sr_next;

    // Full-subtractor cell on the current LSBs; result bit enters at the MSB end.
    always_comb begin
        d       = ra[0] ^ rb[0] ^ br;
        nb      = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        sr_cat  = {d, sr};
        sr_next = sr_cat[WIDTH:1];
        last    = (cnt == LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy/done are registered from the next state so every output comes from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ra   <= '0;
            rb   <= '0;
            sr   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        br  <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    br  <= nb;
                    sr  <= sr_next;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff <= sr_next;
                        bout <= nb;
`ifdef SERIAL_SUB_OVF_EN
                        // br here is the borrow entering the MSB cell.
                        ovf  <= br ^ nb;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1)
// Optional ovf checks follow SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

    int vectors;
    int miscompares;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge with dut8 idle; returns in the same phase, idle again.
    task automatic run_op8(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_bin);
        logic [7:0] exp_d;
        logic       exp_b;
        logic       exp_o;
        logic       early;
        int         full;
        int         sres;
        full  = int'(op_a) - int'(op_b) - int'(op_bin);
        exp_d = full[7:0];
        exp_b = (int'(op_a) < int'(op_b) + int'(op_bin));
        sres  = int'($signed(op_a)) - int'($signed(op_b)) - int'(op_bin);
        exp_o = (sres < -128) || (sres > 127);
        a8 = op_a;
        b8 = op_b;
        bin8 = op_bin;
        start8 = 1'b1;
        @(posedge clk); #1;
        chk("busy_at_accept", busy8, 1);
        chk("done_at_accept", done8, 0);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom_range(0, 1));
        early = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            if (done8 || !busy8) early = 1'b1;
        end
        chk("no_early_done_or_busy_drop", early, 0);
        @(posedge clk); #1;
        chk("done_pulse", done8, 1);
        chk("busy_in_done", busy8, 1);
        chk("diff", diff8, exp_d);
        chk("bout", bout8, exp_b);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf8, exp_o);
`endif
        @(posedge clk); #1;
        chk("done_one_cycle", done8, 0);
        chk("busy_released", busy8, 0);
        chk("diff_held", diff8, exp_d);
    endtask

    task automatic run_op1(input logic op_a, input logic op_b, input logic op_bin);
        int   full;
        logic exp_d;
        logic exp_b;
        full  = int'(op_a) - int'(op_b) - int'(op_bin);
        exp_d = full[0];
        exp_b = (full < 0);
        a1 = op_a;
        b1 = op_b;
        bin1 = op_bin;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = ~op_a;
        b1 = ~op_b;
        chk("w1_busy", busy1, 1);
        @(posedge clk); #1;
        chk("w1_done", done1, 1);
        chk("w1_diff", diff1, exp_d);
        chk("w1_bout", bout1, exp_b);
        @(posedge clk); #1;
        chk("w1_idle", busy1, 0);
    endtask

    initial begin
        logic seen;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bout", bout8, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf8, 0);
`endif
        rst = 1'b0;

        run_op8(8'h05, 8'h03, 1'b0);
        run_op8(8'h03, 8'h05, 1'b0);
        run_op8(8'h00, 8'h00, 1'b1);
        run_op8(8'h80, 8'h01, 1'b0);
        run_op8(8'hFF, 8'hFF, 1'b1);
        run_op8(8'h7F, 8'h01, 1'b0);

        // Reset during the third RUN cycle.
        a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_diff", diff8, 0);
        chk("midrst_bout", bout8, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("midrst_ovf", ovf8, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);
        run_op8(8'h10, 8'h01, 1'b0);

        // start held high with changing operands through RUN/DONE.
        a8 = 8'h20; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h00; b8 = 8'hFF;
        repeat (7) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        chk("hold_first_done", done8, 1);
        chk("hold_first_diff", diff8, 8'h10);
        chk("hold_first_bout", bout8, 0);
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy8) start8 = 1'b0;
            if (done8) seen = 1'b1;
        end
        start8 = 1'b0;
        chk("hold_second_done_seen", seen, 1);
        chk("hold_second_diff", diff8, 8'h01);
        chk("hold_second_bout", bout8, 1);
        @(posedge clk); #1;
        chk("hold_idle_after", busy8, 0);

        for (int n = 0; n < 24; n++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        for (int c = 0; c < 8; c++) begin
            logic [2:0] combo;
            combo = 3'(c);
            run_op1(combo[2], combo[1], combo[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
